// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package icache_pkg;

    localparam int WORDS_PER_LINE = 4;

    typedef logic [7:0]   line_addr_t;
    typedef logic [9:0]   word_addr_t;
    typedef logic [127:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAT       = 3'd1,
        ST_READ      = 3'd2,
        ST_RESP      = 3'd3,
        ST_WAIT_DROP = 3'd4
    } resp_state_t;

endpackage

// File: rtl/imem_word_ram.sv
// 1024 x 32 instruction word store, one synchronous read port and one write port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; both ports accept every cycle. Contents are never reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered word.
module imem_word_ram
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  word_addr_t  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  word_addr_t  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [0:1023];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/icache_mem_responder.sv
// Serves cache line refills from a word RAM, which is also loadable by a program-load port.
// Latency: mem_comp_o pulses LATENCY+5 cycles after the accepting edge.
// Backpressure: requests are level-held by the cache; loads outside IDLE are dropped and flagged.
// Ports: clk/reset; mem_req_i/addr_mem_i refill request; mem_comp_o/mem_data_o response;
//        busy_o; load_en_i/load_addr_i/load_data_i write port; load_drop_o; resp_count_o.
module icache_mem_responder
    import icache_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_req_i,
    input  logic [7:0]   addr_mem_i,
    output logic         mem_comp_o,
    output logic [127:0] mem_data_o,
    output logic         busy_o,
    input  logic         load_en_i,
    input  logic [9:0]   load_addr_i,
    input  logic [31:0]  load_data_i,
    output logic         load_drop_o,
    output logic [15:0]  resp_count_o
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);
    localparam bit         ZERO_LAT = (LATENCY == 0);

    resp_state_t state, next_state;
    line_addr_t  line_q;
    logic [3:0]  lat_cnt;
    logic [2:0]  beat;
    logic [95:0] line_buf;   // words 0..2; word 3 goes straight into mem_data_o
    logic [15:0] cnt_q;
    logic        accept;
    logic        ram_wr_en;
    logic        ram_rd_en;
    word_addr_t  ram_rd_addr;
    logic [31:0] ram_rd_data;

    // A simultaneous load takes priority; the level request is picked up once load_en_i drops.
    assign accept    = (state == ST_IDLE) && mem_req_i && !load_en_i;
    assign ram_wr_en = (state == ST_IDLE) && load_en_i;

    // Beats 0..3 issue word reads; beat 4 only collects the last word.
    assign ram_rd_en   = (state == ST_READ) && !beat[2];
    assign ram_rd_addr = {line_q, beat[1:0]};

    imem_word_ram u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (load_addr_i),
        .wr_data (load_data_i),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ZERO_LAT ? ST_READ : ST_LAT;
                end
            end
            ST_LAT: begin
                if (lat_cnt == 4'd1) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (beat == 3'd4) begin
                    next_state = ST_RESP;
                end
            end
            // A request still held after its response must not be served twice.
            ST_RESP: begin
                next_state = mem_req_i ? ST_WAIT_DROP : ST_IDLE;
            end
            ST_WAIT_DROP: begin
                if (!mem_req_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            line_q      <= '0;
            lat_cnt     <= '0;
            beat        <= '0;
            line_buf    <= '0;
            mem_data_o  <= '0;
            cnt_q       <= '0;
            load_drop_o <= 1'b0;
        end else begin
            state       <= next_state;
            load_drop_o <= load_en_i && (state != ST_IDLE);

            if (accept) begin
                line_q  <= addr_mem_i;
                lat_cnt <= LAT_INIT;
                beat    <= '0;
            end

            if (state == ST_LAT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (state == ST_READ) begin
                beat <= beat + 3'd1;
                case (beat)
                    3'd1: line_buf[31:0]  <= ram_rd_data;
                    3'd2: line_buf[63:32] <= ram_rd_data;
                    3'd3: line_buf[95:64] <= ram_rd_data;
                    // Whole line lands at once, so mem_data_o is never seen half-updated.
                    3'd4: begin
                        mem_data_o <= {ram_rd_data, line_buf};
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_comp_o   = (state == ST_RESP);
    assign busy_o       = (state != ST_IDLE);
    assign resp_count_o = cnt_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
module tb_icache_mem_responder;
    import icache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT A: LATENCY=2, DUT B: LATENCY=0
    logic         rst_a, req_a, comp_a, busy_a, lden_a, drop_a;
    logic [7:0]   addr_a;
    logic [9:0]   ldaddr_a;
    logic [31:0]  lddata_a;
    logic [127:0] data_a;
    logic [15:0]  cnt_a;

    logic         rst_b, req_b, comp_b, busy_b, lden_b, drop_b;
    logic [7:0]   addr_b;
    logic [9:0]   ldaddr_b;
    logic [31:0]  lddata_b;
    logic [127:0] data_b;
    logic [15:0]  cnt_b;

    icache_mem_responder #(.LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_a), .mem_req_i(req_a), .addr_mem_i(addr_a),
        .mem_comp_o(comp_a), .mem_data_o(data_a), .busy_o(busy_a),
        .load_en_i(lden_a), .load_addr_i(ldaddr_a), .load_data_i(lddata_a),
        .load_drop_o(drop_a), .resp_count_o(cnt_a)
    );

    icache_mem_responder #(.LATENCY(0)) dut_b (
        .clk(clk), .reset(rst_b), .mem_req_i(req_b), .addr_mem_i(addr_b),
        .mem_comp_o(comp_b), .mem_data_o(data_b), .busy_o(busy_b),
        .load_en_i(lden_b), .load_addr_i(ldaddr_b), .load_data_i(lddata_b),
        .load_drop_o(drop_b), .resp_count_o(cnt_b)
    );

    typedef struct {
        logic [127:0] data;
        int           cyc;
        logic [15:0]  cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [31:0] model_a [1024];
    logic [31:0] model_b [1024];
    logic [15:0] cnt_model [2];
    int pulses_a = 0;
    int pulses_b = 0;
    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] line_of(input int sel, input logic [7:0] l);
        logic [127:0] d;
        for (int k = 0; k < WORDS_PER_LINE; k++)
            d[32*k +: 32] = (sel == 0) ? model_a[{l, 2'(k)}] : model_b[{l, 2'(k)}];
        return d;
    endfunction

    // Monitors: every mem_comp_o cycle must match the head of that DUT's queue.
    always @(negedge clk) begin
        if (!rst_a && comp_a) begin
            pulses_a++;
            if (q_a.size() == 0) begin
                total++;
                $display("FAIL a_unexpected_comp: pulse at cycle %0d with no request outstanding", cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_resp_data", data_a, e.data);
                check("a_resp_cycle", 128'(cyc), 128'(e.cyc));
                check("a_resp_count", 128'(cnt_a), 128'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && comp_b) begin
            pulses_b++;
            if (q_b.size() == 0) begin
                total++;
                $display("FAIL b_unexpected_comp: pulse at cycle %0d with no request outstanding", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_resp_data", data_b, e.data);
                check("b_resp_cycle", 128'(cyc), 128'(e.cyc));
                check("b_resp_count", 128'(cnt_b), 128'(e.cnt));
            end
        end
    end

    // Called at a negedge with the DUT idle; leaves load_en high for one edge.
    task automatic load_word(input int sel, input logic [9:0] a, input logic [31:0] d);
        if (sel == 0) begin
            lden_a = 1'b1; ldaddr_a = a; lddata_a = d; model_a[a] = d;
        end else begin
            lden_b = 1'b1; ldaddr_b = a; lddata_b = d; model_b[a] = d;
        end
        @(negedge clk);
        if (sel == 0) lden_a = 1'b0; else lden_b = 1'b0;
    endtask

    // Raises the request at a negedge; delay = extra edges before acceptance.
    task automatic start_req(input int sel, input logic [7:0] l, input int delay,
                             input bit expect_resp, output int e0);
        exp_t e;
        if (sel == 0) begin req_a = 1'b1; addr_a = l; end
        else begin req_b = 1'b1; addr_b = l; end
        e0 = cyc + 1 + delay;
        if (expect_resp) begin
            if (cnt_model[sel] != 16'hFFFF) cnt_model[sel] = cnt_model[sel] + 16'd1;
            e.data = line_of(sel, l);
            e.cyc  = e0 + ((sel == 0) ? 2 : 0) + 5;
            e.cnt  = cnt_model[sel];
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
    endtask

    // Waits (bounded) for the completion pulse; optionally drops the request in that cycle.
    task automatic wait_comp(input int sel, input bit drop);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (sel == 0) ? comp_a : comp_b;
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_comp_timeout: no mem_comp_o within 40 cycles", (sel == 0) ? "a" : "b");
        end
        if (drop) begin
            if (sel == 0) req_a = 1'b0; else req_b = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int p;
        rst_a = 1'b1; req_a = 1'b0; addr_a = '0; lden_a = 1'b0; ldaddr_a = '0; lddata_a = '0;
        rst_b = 1'b1; req_b = 1'b0; addr_b = '0; lden_b = 1'b0; ldaddr_b = '0; lddata_b = '0;
        cnt_model[0] = '0;
        cnt_model[1] = '0;
        repeat (3) @(negedge clk);

        check("a_rst_comp", 128'(comp_a), 128'(0));
        check("a_rst_data", data_a, 128'(0));
        check("a_rst_busy", 128'(busy_a), 128'(0));
        check("a_rst_drop", 128'(drop_a), 128'(0));
        check("a_rst_count", 128'(cnt_a), 128'(0));
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Basic refill of line 0x2A, LATENCY=2, held afterwards.
        load_word(0, {8'h2A, 2'd0}, 32'h11111111);
        load_word(0, {8'h2A, 2'd1}, 32'h22222222);
        load_word(0, {8'h2A, 2'd2}, 32'h33333333);
        load_word(0, {8'h2A, 2'd3}, 32'h44444444);
        check("a_line_model", line_of(0, 8'h2A), 128'h44444444_33333333_22222222_11111111);
        start_req(0, 8'h2A, 0, 1, e0);
        @(negedge clk);
        addr_a = 8'h33;   // must be ignored after acceptance
        p = pulses_a;
        wait_comp(0, 0);
        repeat (10) @(negedge clk);
        check("a_held_pulses", 128'(pulses_a - p), 128'(1));
        check("a_held_busy", 128'(busy_a), 128'(1));
        check("a_held_state", 128'(dut_a.state), 128'(ST_WAIT_DROP));
        req_a = 1'b0;
        @(negedge clk);
        check("a_drop_busy", 128'(busy_a), 128'(0));

        // Load during READ is dropped; readback shows the old word.
        start_req(0, 8'h2A, 0, 1, e0);
        while (cyc < e0 + 2) @(negedge clk);
        check("a_in_read", 128'(dut_a.state), 128'(ST_READ));
        lden_a = 1'b1; ldaddr_a = {8'h2A, 2'd1}; lddata_a = 32'hDEADBEEF;
        @(negedge clk);
        lden_a = 1'b0;
        check("a_load_drop", 128'(drop_a), 128'(1));
        wait_comp(0, 1);
        @(negedge clk);
        check("a_drop_cleared", 128'(drop_a), 128'(0));
        start_req(0, 8'h2A, 0, 1, e0);
        wait_comp(0, 1);
        @(negedge clk);

        // Load and request in the same IDLE cycle: load first, then the request.
        lden_a = 1'b1; ldaddr_a = {8'h2A, 2'd2}; lddata_a = 32'hCAFEF00D;
        model_a[{8'h2A, 2'd2}] = 32'hCAFEF00D;
        start_req(0, 8'h2A, 1, 1, e0);
        @(negedge clk);
        lden_a = 1'b0;
        wait_comp(0, 1);
        @(negedge clk);

        // Reset in READ beat 2 abandons the request.
        start_req(0, 8'h10, 0, 0, e0);
        while (cyc < e0 + 4) @(negedge clk);
        check("a_beat2", 128'(dut_a.beat), 128'(2));
        rst_a = 1'b1;
        #1;
        check("a_midrst_busy", 128'(busy_a), 128'(0));
        check("a_midrst_comp", 128'(comp_a), 128'(0));
        req_a = 1'b0;
        cnt_model[0] = '0;
        @(negedge clk);
        rst_a = 1'b0;
        p = pulses_a;
        repeat (20) @(negedge clk);
        check("a_postrst_pulses", 128'(pulses_a - p), 128'(0));
        check("a_postrst_count", 128'(cnt_a), 128'(0));
        // RAM survives reset.
        start_req(0, 8'h2A, 0, 1, e0);
        wait_comp(0, 1);
        @(negedge clk);

        // LATENCY=0 instance.
        load_word(1, {8'h05, 2'd0}, 32'hA0A0A0A0);
        load_word(1, {8'h05, 2'd1}, 32'hB1B1B1B1);
        load_word(1, {8'h05, 2'd2}, 32'hC2C2C2C2);
        load_word(1, {8'h05, 2'd3}, 32'hD3D3D3D3);
        start_req(1, 8'h05, 0, 1, e0);
        wait_comp(1, 1);
        @(negedge clk);
        force dut_b.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut_b.cnt_q;
        cnt_model[1] = 16'hFFFE;
        @(negedge clk);
        check("b_forced_count", 128'(cnt_b), 128'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            start_req(1, 8'h05, 0, 1, e0);
            wait_comp(1, 1);
            @(negedge clk);
        end
        check("b_sat_count", 128'(cnt_b), 128'(16'hFFFF));
        check("a_queue_empty", 128'(q_a.size()), 128'(0));
        check("b_queue_empty", 128'(q_b.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
